// File: rtl/t5_hsch.sv
// Hart scheduler: picks one RUN hart per advancing cycle in round-robin order,
// parks harts with outstanding memory accesses and spaces same-hart issues by GAP.
module t5_hsch #(
    parameter int unsigned NHART = 4,
    parameter int unsigned HW    = 2,
    parameter int unsigned GAP   = 4
) (
    input  logic             sclk,
    input  logic             srst,
    input  logic             sena,
    input  logic [NHART-1:0] hstart,
    input  logic [NHART-1:0] hstop,
    input  logic             xwait,
    input  logic [HW-1:0]    xwhart,
    input  logic             mack,
    input  logic [HW-1:0]    mhart,
    output logic [HW-1:0]    fhart,
    output logic             fvld,
    output logic [NHART-1:0] hrun,
    output logic [NHART-1:0] hbusy
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2
    } hstate_t;

    hstate_t          state_q [NHART];
    hstate_t          state_d [NHART];
    logic [CW-1:0]    cnt_q   [NHART];
    logic [CW-1:0]    cnt_d   [NHART];
    logic [HW-1:0]    ptr_q;
    logic [NHART-1:0] elig;
    logic             sel_vld;
    logic [HW-1:0]    sel;
    logic [HW-1:0]    idx;

    // Per-hart run state transitions and issue eligibility
    always_comb begin
        for (int h = 0; h < NHART; h++) begin
            state_d[h] = state_q[h];
            if (hstop[h]) begin
                state_d[h] = S_HALT;
            end else if (xwait && (xwhart == HW'(h)) && (state_q[h] == S_RUN)) begin
                state_d[h] = S_WAIT;
            end else if (mack && (mhart == HW'(h)) && (state_q[h] == S_WAIT)) begin
                state_d[h] = S_RUN;
            end else if (hstart[h] && (state_q[h] == S_HALT)) begin
                state_d[h] = S_RUN;
            end
            elig[h] = (state_q[h] == S_RUN) && (cnt_q[h] == '0) && !hstop[h]
                      && !(xwait && (xwhart == HW'(h)));
        end
    end

    // Round-robin pick: scan farthest-first so the hart nearest ptr+1 wins
    always_comb begin
        sel_vld = 1'b0;
        sel     = ptr_q;
        idx     = ptr_q;
        for (int i = NHART; i >= 1; i--) begin
            idx = ptr_q + HW'(i);
            if (elig[idx]) begin
                sel_vld = 1'b1;
                sel     = idx;
            end
        end
    end

    always_comb begin
        for (int h = 0; h < NHART; h++) begin
            cnt_d[h] = (cnt_q[h] == '0) ? '0 : cnt_q[h] - CW'(1);
            if (sel_vld && (sel == HW'(h))) begin
                cnt_d[h] = CW'(GAP - 1);
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            for (int h = 0; h < NHART; h++) begin
                state_q[h] <= (h == 0) ? S_RUN : S_HALT;
                cnt_q[h]   <= '0;
            end
            ptr_q <= HW'(NHART - 1);
            fvld  <= 1'b0;
            fhart <= '0;
        end else begin
            for (int h = 0; h < NHART; h++) begin
                state_q[h] <= state_d[h];
            end
            if (sena) begin
                fvld <= sel_vld;
                if (sel_vld) begin
                    fhart <= sel;
                    ptr_q <= sel;
                end
                for (int h = 0; h < NHART; h++) begin
                    cnt_q[h] <= cnt_d[h];
                end
            end
        end
    end

    always_comb begin
        for (int h = 0; h < NHART; h++) begin
            hrun[h]  = (state_q[h] == S_RUN);
            hbusy[h] = (state_q[h] != S_HALT);
        end
    end

endmodule

// File: tb/tb_t5_hsch.sv
// Scoreboard bench for t5_hsch: an issue-history reference model predicts each
// advancing cycle's fetch pick; a monitor compares it and the run-state decode.
module tb_t5_hsch;

    localparam int unsigned NHART = 4;
    localparam int unsigned HW    = 2;
    localparam int unsigned GAP   = 4;
    localparam int M_HALT = 0;
    localparam int M_RUN  = 1;
    localparam int M_WAIT = 2;

    logic             sclk = 1'b0;
    logic             srst;
    logic             sena;
    logic [NHART-1:0] hstart;
    logic [NHART-1:0] hstop;
    logic             xwait;
    logic [HW-1:0]    xwhart;
    logic             mack;
    logic [HW-1:0]    mhart;
    logic [HW-1:0]    fhart;
    logic             fvld;
    logic [NHART-1:0] hrun;
    logic [NHART-1:0] hbusy;

    t5_hsch #(.NHART(NHART), .HW(HW), .GAP(GAP)) dut (
        .sclk(sclk), .srst(srst), .sena(sena), .hstart(hstart), .hstop(hstop),
        .xwait(xwait), .xwhart(xwhart), .mack(mack), .mhart(mhart),
        .fhart(fhart), .fvld(fvld), .hrun(hrun), .hbusy(hbusy)
    );

    always #5 sclk = ~sclk;

    typedef struct packed {
        logic          v;
        logic [HW-1:0] h;
    } exp_t;

    exp_t          q[$];
    int            checks   = 0;
    int            failures = 0;
    int            st   [NHART];
    int            last [NHART];
    int            rr;
    int            scnt;
    logic [HW-1:0] m_fh;
    logic          mon_rst;
    logic          mon_adv;
    exp_t          mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [NHART-1:0] m_vec(input int want, input bit neg);
        logic [NHART-1:0] v;
        for (int h = 0; h < NHART; h++) v[h] = neg ? (st[h] != want) : (st[h] == want);
        return v;
    endfunction

    // Reference: a hart may issue once GAP advancing cycles have elapsed since its last issue
    task automatic model_step();
        logic [NHART-1:0] el;
        bit   any;
        int   sel;
        exp_t e;
        if (srst) begin
            for (int h = 0; h < NHART; h++) begin
                st[h]   = (h == 0) ? M_RUN : M_HALT;
                last[h] = -1000;
            end
            rr   = NHART - 1;
            scnt = 0;
            m_fh = '0;
            return;
        end
        for (int h = 0; h < NHART; h++)
            el[h] = (st[h] == M_RUN) && (scnt - last[h] >= int'(GAP)) && !hstop[h]
                    && !(xwait && xwhart == h);
        if (sena) begin
            any = 0;
            sel = 0;
            for (int k = 1; k <= NHART; k++) begin
                if (!any && el[(rr + k) % NHART]) begin
                    any = 1;
                    sel = (rr + k) % NHART;
                end
            end
            if (any) begin
                last[sel] = scnt;
                rr        = sel;
                m_fh      = HW'(sel);
            end
            e.v = any;
            e.h = m_fh;
            q.push_back(e);
            scnt++;
        end
        for (int h = 0; h < NHART; h++) begin
            if (hstop[h])                                         st[h] = M_HALT;
            else if (xwait && xwhart == h && st[h] == M_RUN)      st[h] = M_WAIT;
            else if (mack && mhart == h && st[h] == M_WAIT)       st[h] = M_RUN;
            else if (hstart[h] && st[h] == M_HALT)                st[h] = M_RUN;
        end
    endtask

    task automatic cyc(input logic rst, input logic en, input logic [NHART-1:0] sta,
                       input logic [NHART-1:0] sto, input logic xw, input logic [HW-1:0] xh,
                       input logic mk, input logic [HW-1:0] mh);
        @(negedge sclk);
        srst = rst; sena = en; hstart = sta; hstop = sto;
        xwait = xw; xwhart = xh; mack = mk; mhart = mh;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, '0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    // Monitor: consume one expectation per advancing edge, check state decode every edge
    always @(posedge sclk) begin
        mon_rst = srst;
        mon_adv = sena && !srst;
        #1;
        if (mon_rst) begin
            check("rst_fvld", 32'(fvld), 32'd0);
            check("rst_fhart", 32'(fhart), 32'd0);
        end else if (mon_adv) begin
            if (q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("fvld", 32'(fvld), 32'(mon_e.v));
                check("fhart", 32'(fhart), 32'(mon_e.h));
            end
        end
        check("hrun", 32'(hrun), 32'(m_vec(M_RUN, 0)));
        check("hbusy", 32'(hbusy), 32'(m_vec(M_HALT, 1)));
    end

    initial begin
        srst = 1'b1; sena = 1'b0; hstart = '0; hstop = '0;
        xwait = 1'b0; xwhart = '0; mack = 1'b0; mhart = '0;
        model_step();
        cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
        // lone hart0 spaced by GAP
        idle(9);
        // start harts 1..3
        cyc(1'b0, 1'b1, 4'b1110, '0, 1'b0, '0, 1'b0, '0);
        idle(8);
        // hart2 parks on a memory access, then resumes
        cyc(1'b0, 1'b1, '0, '0, 1'b1, 2'd2, 1'b0, '0);
        idle(2);
        cyc(1'b0, 1'b1, '0, '0, 1'b0, '0, 1'b1, 2'd2);
        idle(6);
        // stop beats wait for hart0; stray ack ignored
        cyc(1'b0, 1'b1, '0, 4'b0001, 1'b1, 2'd0, 1'b0, '0);
        idle(3);
        cyc(1'b0, 1'b1, '0, '0, 1'b0, '0, 1'b1, 2'd0);
        idle(3);
        // frozen pipeline while hart1 restarts
        cyc(1'b0, 1'b1, '0, 4'b0010, 1'b0, '0, 1'b0, '0);
        cyc(1'b0, 1'b0, 4'b0010, '0, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
        idle(6);
        // reset with harts 1 and 3 waiting
        cyc(1'b0, 1'b1, 4'b1011, '0, 1'b1, 2'd1, 1'b0, '0);
        cyc(1'b0, 1'b1, '0, '0, 1'b1, 2'd3, 1'b0, '0);
        cyc(1'b1, 1'b1, '0, '0, 1'b0, '0, 1'b0, '0);
        idle(5);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 9) != 0),
                NHART'($urandom & $urandom & $urandom),
                ($urandom_range(0, 11) == 0) ? NHART'(1 << $urandom_range(0, NHART - 1)) : '0,
                ($urandom_range(0, 3) == 0), HW'($urandom),
                ($urandom_range(0, 2) == 0), HW'($urandom));
        end
        @(posedge sclk);
        #2;
        check("sb_drain", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
